muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the execute stage. It supersedes the multiply-only unit and adds signed/unsigned divide, an abort input, a busy flag and a divide-by-zero flag. Operands are latched on Start. The result appears on Hi/Lo after a fixed latency and is flagged by a one-cycle Valid pulse. The hazard unit stalls on Busy and consumes Valid; Hi/Lo feed the execute output mux.

Parameters:
WIDTH, 32, operand width in bits (must be >= 4); Hi and Lo are each WIDTH bits wide.

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
Start  input  1  latch SrcA/SrcB/Mode and begin an operation
Abort  input  1  cancel the operation in flight (e.g. on a flush)
Mode  input  2  00 multu, 01 mult, 10 divu, 11 div
SrcA  input  WIDTH  multiplicand / dividend
SrcB  input  WIDTH  multiplier / divisor
Busy  output  1  operation in flight; further Start is ignored
Valid  output  1  one-cycle pulse: Hi/Lo updated this cycle
Hi  output  WIDTH  product upper half / remainder
Lo  output  WIDTH  product lower half / quotient
DivByZero  output  1  last completed divide had SrcB == 0

Behaviour:
- Reset: RESET high at an edge forces state IDLE, Busy=0, Valid=0, Hi=0, Lo=0, DivByZero=0, iteration counter=0. RESET overrides Start and Abort, including mid-operation.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, exactly WIDTH cycles, counter WIDTH-1 down to 0.
  - FIX: Busy=1, 1 cycle, sign correction and result formation.
  - DONE: Busy=0, Valid=1, 1 cycle.
- Transitions:
  - IDLE or DONE, Start=1 and Abort=0 -> RUN. Operands and Mode are latched at that edge.
  - IDLE or DONE, otherwise: DONE -> IDLE, IDLE stays IDLE.
  - RUN: -> FIX when counter=0.
  - FIX -> DONE.
  - RUN or FIX with Abort=1 -> IDLE. Valid is not asserted; Hi, Lo and DivByZero keep their previous values.
- Latency: if Start is high in cycle k, Busy is high in cycles k+1..k+WIDTH+1 and Valid is high in cycle k+WIDTH+2. Hi/Lo change only at the edge entering DONE and hold until the next completion.
- Start while Busy=1 is ignored and has no effect on the operation in flight. Start in the DONE cycle is accepted (back-to-back operation).
- Signed modes (01, 11): convert operands to magnitudes at Start. FIX negates results as required. The magnitude of the most-negative value is handled as an unsigned 2^(WIDTH-1).
- Multiply: radix-2 shift-add, one partial product per RUN cycle. {Hi,Lo} is the full 2*WIDTH-bit product, so there is no overflow.
- Divide: restoring shift-subtract, one quotient bit per RUN cycle.
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Lo=quotient, Hi=remainder.
- Divide by zero (SrcB == 0 in mode 10/11): full latency is still taken. Result is Lo = all ones, Hi = SrcA as latched, DivByZero=1.
- DivByZero is updated at every completion: 0 for multiplies and nonzero divides. It holds between completions.
- Signed overflow (most-negative / -1): Lo = most-negative value, Hi = 0, DivByZero=0.
- Abort and Start in the same cycle while in IDLE/DONE: Abort wins, the state goes to IDLE and nothing is latched.
- Outputs are registered. There is no combinational path from any input to Busy, Valid, Hi, Lo or DivByZero.

Test Plan:
- WIDTH=32, multu, SrcA=SrcB=0xFFFFFFFF, Start in cycle 0 -> Busy cycles 1..33. Valid only in cycle 34 with Hi=0xFFFFFFFE, Lo=0x00000001, DivByZero=0.
- mult -3 x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Then, in the DONE cycle, Start div with -7 / 2 -> after 34 cycles Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- divu 5 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000005, DivByZero=1 with Valid. A following multu 2 x 3 -> Hi=0, Lo=6, DivByZero=0.
- div 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivByZero=0. divu 100 / 7 -> Lo=14, Hi=2.
- Complete multu 2 x 3 (Lo=6). Then Start divu 9 / 3 and assert Abort in cycle 10 -> Busy=0 from cycle 11, Valid never asserted, Hi=0, Lo=6 unchanged. Start pulses during a Busy window are ignored: exactly one Valid, with the first operands' result.
- RESET in the middle of RUN -> next cycle Busy=0, Valid=0, Hi=Lo=0. Rerun with WIDTH=8: mult 0x80 x 0x80 -> Valid at cycle 10, Hi=0x40, Lo=0x00.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Handshake/operand bundle between the execute stage and the iterative
// multiply/divide unit. Signal prefixes are from the unit's point of view.
//   i_start       : latch operands/mode and begin an operation
//   i_abort       : cancel the operation in flight
//   i_mode        : 00 multu, 01 mult, 10 divu, 11 div
//   i_src_a       : multiplicand / dividend
//   i_src_b       : multiplier / divisor
//   o_busy        : operation in flight, further starts ignored
//   o_valid       : one-cycle pulse, o_hi/o_lo updated this cycle
//   o_hi          : product upper half / remainder
//   o_lo          : product lower half / quotient
//   o_div_by_zero : last completed divide had a zero divisor
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_abort;
  logic [1:0]       i_mode;
  logic [WIDTH-1:0] i_src_a;
  logic [WIDTH-1:0] i_src_b;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;
  logic             o_div_by_zero;

  // Requester side (execute stage / hazard unit)
  modport master (
    output i_start, i_abort, i_mode, i_src_a, i_src_b,
    input  o_busy, o_valid, o_hi, o_lo, o_div_by_zero
  );

  // Unit side
  modport slave (
    input  i_start, i_abort, i_mode, i_src_a, i_src_b,
    output o_busy, o_valid, o_hi, o_lo, o_div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit. Signed operands are reduced to magnitudes
// when the operation starts, WIDTH shift-add (multiply) or restoring
// shift-subtract (divide) steps run, then one cycle applies sign correction
// and forms the result, which is published with a one-cycle valid pulse.
// Ports:
//   i_clk : clock, all state updates on the rising edge
//   i_rst : synchronous active-high reset
//   bus   : muldiv_unit_if slave modport (start/abort/mode/operands in,
//           busy/valid/hi/lo/div_by_zero out, all outputs registered)
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;        // partial product high / partial remainder
  logic [WIDTH-1:0] r_lo;        // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] r_b;         // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_src_a;     // raw dividend, returned on divide by zero
  logic             r_is_div;
  logic             r_neg_q;     // product / quotient must be negated
  logic             r_neg_r;     // remainder must be negated
  logic             r_b_zero;

  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_dbz;

  logic             w_accept;
  logic             w_a_sgn;
  logic             w_b_sgn;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;
  logic             w_fix_dbz;

  // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1)
  // which is representable as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic             is_signed);
    if (is_signed && v[WIDTH-1]) begin
      mag = {WIDTH{1'b0}} - v;
    end else begin
      mag = v;
    end
  endfunction

  // Abort has priority over start in the idle/done states.
  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                    bus.i_start && !bus.i_abort;
  assign w_a_sgn  = bus.i_mode[0] & bus.i_src_a[WIDTH-1];
  assign w_b_sgn  = bus.i_mode[0] & bus.i_src_b[WIDTH-1];

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.i_abort) begin
          w_next = S_IDLE;
        end else if (r_cnt == {CW{1'b0}}) begin
          w_next = S_FIX;
        end else begin
          w_next = S_RUN;
        end
      end
      S_FIX: begin
        if (bus.i_abort) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Single-step arithmetic for both algorithms.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} +
                  (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    // When the trial subtraction succeeds the result is below the divisor,
    // so the dropped top bit is always zero.
    w_div_rem   = w_div_shift[WIDTH-1:0] - r_b;
  end

  // Sign correction and result selection for the FIX cycle.
  always_comb begin
    w_prod_fix = r_neg_q ? ({(2*WIDTH){1'b0}} - {r_hi, r_lo}) : {r_hi, r_lo};
    w_q_fix    = r_neg_q ? ({WIDTH{1'b0}} - r_lo) : r_lo;
    w_r_fix    = r_neg_r ? ({WIDTH{1'b0}} - r_hi) : r_hi;
    w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
    w_fix_lo   = w_prod_fix[WIDTH-1:0];
    w_fix_dbz  = 1'b0;
    if (!r_is_div) begin
      w_fix_hi  = w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo  = w_prod_fix[WIDTH-1:0];
      w_fix_dbz = 1'b0;
    end else if (r_b_zero) begin
      w_fix_hi  = r_src_a;
      w_fix_lo  = {WIDTH{1'b1}};
      w_fix_dbz = 1'b1;
    end else begin
      w_fix_hi  = w_r_fix;
      w_fix_lo  = w_q_fix;
      w_fix_dbz = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Status outputs registered from the next state so they track the FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_next == S_RUN) || (w_next == S_FIX);
      r_valid <= (w_next == S_DONE);
    end
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= {CW{1'b0}};
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_src_a  <= {WIDTH{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_res_hi <= {WIDTH{1'b0}};
      r_res_lo <= {WIDTH{1'b0}};
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_cnt    <= CW'(WIDTH - 1);
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= mag(bus.i_src_a, bus.i_mode[0]);
            r_b      <= mag(bus.i_src_b, bus.i_mode[0]);
            r_src_a  <= bus.i_src_a;
            r_is_div <= bus.i_mode[1];
            r_neg_q  <= w_a_sgn ^ w_b_sgn;
            r_neg_r  <= w_a_sgn;
            r_b_zero <= (bus.i_src_b == {WIDTH{1'b0}});
          end
        end
        S_RUN: begin
          if (!bus.i_abort) begin
            if (r_cnt != {CW{1'b0}}) begin
              r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
            end
            if (!r_is_div) begin
              r_hi <= w_mul_sum[WIDTH:1];
              r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            end else if (w_div_ge) begin
              r_hi <= w_div_rem;
              r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_hi <= w_div_shift[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
          end
        end
        S_FIX: begin
          // Results change only on the edge that enters DONE.
          if (!bus.i_abort) begin
            r_res_hi <= w_fix_hi;
            r_res_lo <= w_fix_lo;
            r_dbz    <= w_fix_dbz;
          end
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_valid       = r_valid;
  assign bus.o_hi          = r_res_hi;
  assign bus.o_lo          = r_res_lo;
  assign bus.o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit, with a 32-bit and an 8-bit
// instance sharing clock and reset. Inputs are driven and outputs sampled on
// the falling edge; cycle c of an operation is the c-th falling edge after
// the one where start was driven.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   lat;
  int   busy_n;
  int   valid_n;
  int   busy_bad;
  logic [31:0] cap_lo;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.i_clk(clk), .i_rst(rst), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.i_clk(clk), .i_rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input bit w8);
    return w8 ? bus8.o_busy : bus32.o_busy;
  endfunction
  function automatic logic get_valid(input bit w8);
    return w8 ? bus8.o_valid : bus32.o_valid;
  endfunction
  function automatic logic [31:0] get_hi(input bit w8);
    return w8 ? {24'h0, bus8.o_hi} : bus32.o_hi;
  endfunction
  function automatic logic [31:0] get_lo(input bit w8);
    return w8 ? {24'h0, bus8.o_lo} : bus32.o_lo;
  endfunction
  function automatic logic get_dbz(input bit w8);
    return w8 ? bus8.o_div_by_zero : bus32.o_div_by_zero;
  endfunction

  task automatic drive(input bit w8, input logic st, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      bus8.i_start = st;  bus8.i_mode = mode;
      bus8.i_src_a = a[7:0]; bus8.i_src_b = b[7:0];
    end else begin
      bus32.i_start = st; bus32.i_mode = mode;
      bus32.i_src_a = a;  bus32.i_src_b = b;
    end
  endtask

  // Starts an operation at the current falling edge and returns at the
  // falling edge where valid is seen (lat = 0 if it never appears).
  task automatic do_op(input bit w8, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b,
                       output int o_lat, output int o_busy_n);
    drive(w8, 1'b1, mode, a, b);
    o_lat = 0;
    o_busy_n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus8.i_start = 1'b0;
        bus32.i_start = 1'b0;
      end
      if (get_busy(w8)) o_busy_n++;
      if (get_valid(w8)) begin
        o_lat = c;
        break;
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus32.i_abort = 1'b0;
    bus8.i_abort  = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy",  {63'h0, bus32.o_busy}, 64'h0);
    check("rst_valid", {63'h0, bus32.o_valid}, 64'h0);
    check("rst_hi",    {32'h0, bus32.o_hi}, 64'h0);
    check("rst_lo",    {32'h0, bus32.o_lo}, 64'h0);
    check("rst_dbz",   {63'h0, bus32.o_div_by_zero}, 64'h0);
    check("rst8_lo",   {56'h0, bus8.o_lo}, 64'h0);
    @(negedge clk);

    // multu 0xFFFFFFFF^2: busy 1..33, valid at 34
    do_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_n);
    check("multu_lat",  lat, 34);
    check("multu_busy", busy_n, 33);
    check("multu_hi",   get_hi(0), 32'hFFFF_FFFE);
    check("multu_lo",   get_lo(0), 32'h0000_0001);
    check("multu_dbz",  get_dbz(0), 1'b0);
    @(negedge clk);
    check("valid_pulse", get_valid(0), 1'b0);
    check("idle_busy",   get_busy(0), 1'b0);

    // mult -3 x 7, then back-to-back div -7 / 2 started in the DONE cycle
    do_op(1'b0, 2'b01, 32'hFFFF_FFFD, 32'd7, lat, busy_n);
    check("mult_hi", get_hi(0), 32'hFFFF_FFFF);
    check("mult_lo", get_lo(0), 32'hFFFF_FFEB);
    do_op(1'b0, 2'b11, 32'hFFFF_FFF9, 32'd2, lat, busy_n);
    check("b2b_lat", lat, 34);
    check("div_lo",  get_lo(0), 32'hFFFF_FFFD);
    check("div_hi",  get_hi(0), 32'hFFFF_FFFF);

    // div 7 / -2 -> q = -3, r = 1 (remainder follows dividend sign)
    do_op(1'b0, 2'b11, 32'd7, 32'hFFFF_FFFE, lat, busy_n);
    check("divpn_lo", get_lo(0), 32'hFFFF_FFFD);
    check("divpn_hi", get_hi(0), 32'h0000_0001);

    // divu 5 / 0, then multu 2 x 3 clears the flag
    do_op(1'b0, 2'b10, 32'd5, 32'd0, lat, busy_n);
    check("dbz_lat", lat, 34);
    check("dbz_lo",  get_lo(0), 32'hFFFF_FFFF);
    check("dbz_hi",  get_hi(0), 32'h0000_0005);
    check("dbz_flag", get_dbz(0), 1'b1);
    @(negedge clk);
    check("dbz_hold", get_dbz(0), 1'b1);
    do_op(1'b0, 2'b00, 32'd2, 32'd3, lat, busy_n);
    check("m23_hi",  get_hi(0), 32'h0);
    check("m23_lo",  get_lo(0), 32'd6);
    check("m23_dbz", get_dbz(0), 1'b0);

    // Signed overflow and an unsigned divide
    do_op(1'b0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, busy_n);
    check("ovf_lo",  get_lo(0), 32'h8000_0000);
    check("ovf_hi",  get_hi(0), 32'h0);
    check("ovf_dbz", get_dbz(0), 1'b0);
    do_op(1'b0, 2'b10, 32'd100, 32'd7, lat, busy_n);
    check("divu_lo", get_lo(0), 32'd14);
    check("divu_hi", get_hi(0), 32'd2);

    // Abort: complete multu 2 x 3, then abort divu 9 / 3 in cycle 10
    do_op(1'b0, 2'b00, 32'd2, 32'd3, lat, busy_n);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 32'd9, 32'd3);
    valid_n = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (c == 1) bus32.i_start = 1'b0;
      if (get_valid(0)) valid_n++;
      if (c == 9) check("abort_busy_pre", get_busy(0), 1'b1);
      if (c == 10) bus32.i_abort = 1'b1;
      if (c == 11) begin
        bus32.i_abort = 1'b0;
        check("abort_busy", get_busy(0), 1'b0);
      end
    end
    check("abort_valid", valid_n, 0);
    check("abort_hi", get_hi(0), 32'h0);
    check("abort_lo", get_lo(0), 32'd6);

    // Abort together with start while idle: nothing starts
    drive(1'b0, 1'b1, 2'b00, 32'd4, 32'd4);
    bus32.i_abort = 1'b1;
    @(negedge clk);
    bus32.i_start = 1'b0;
    bus32.i_abort = 1'b0;
    check("abort_start_busy", get_busy(0), 1'b0);

    // Start pulses while busy are ignored
    drive(1'b0, 1'b1, 2'b00, 32'd3, 32'd5);
    valid_n = 0;
    busy_bad = 0;
    cap_lo = 32'h0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      bus32.i_start = 1'b0;
      if (c <= 33 && !get_busy(0)) busy_bad++;
      if (get_valid(0)) begin
        valid_n++;
        cap_lo = get_lo(0);
      end
      if (c == 5 || c == 20 || c == 33) drive(1'b0, 1'b1, 2'b00, 32'd7, 32'd7);
    end
    check("ign_valid_n", valid_n, 1);
    check("ign_busy",    busy_bad, 0);
    check("ign_lo",      cap_lo, 32'd15);

    // Reset in the middle of RUN
    drive(1'b0, 1'b1, 2'b00, 32'd9, 32'd9);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus32.i_start = 1'b0;
      if (c == 10) rst = 1'b1;
    end
    check("mrst_busy",  get_busy(0), 1'b0);
    check("mrst_valid", get_valid(0), 1'b0);
    check("mrst_hi",    get_hi(0), 32'h0);
    check("mrst_lo",    get_lo(0), 32'h0);
    rst = 1'b0;
    valid_n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (get_valid(0)) valid_n++;
    end
    check("mrst_no_valid", valid_n, 0);

    // WIDTH = 8 instance
    do_op(1'b1, 2'b01, 32'h80, 32'h80, lat, busy_n);
    check("w8_lat",  lat, 10);
    check("w8_busy", busy_n, 9);
    check("w8_hi",   get_hi(1), 32'h40);
    check("w8_lo",   get_lo(1), 32'h00);
    do_op(1'b1, 2'b11, 32'h80, 32'hFF, lat, busy_n);
    check("w8_ovf_lo", get_lo(1), 32'h80);
    check("w8_ovf_hi", get_hi(1), 32'h00);
    do_op(1'b1, 2'b10, 32'hFF, 32'h10, lat, busy_n);
    check("w8_divu_lo", get_lo(1), 32'h0F);
    check("w8_divu_hi", get_hi(1), 32'h0F);
    do_op(1'b1, 2'b10, 32'd200, 32'd0, lat, busy_n);
    check("w8_dbz_lo",   get_lo(1), 32'hFF);
    check("w8_dbz_hi",   get_hi(1), 32'hC8);
    check("w8_dbz_flag", get_dbz(1), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
